i2so_serializer: RTL

I2S master transmitter for the `i2so` output path, the transmit-side counterpart of the `i2si` receive path. It accepts stereo samples over a valid/ready handshake into a one-entry buffer. It generates `i2so_sck` and `i2so_ws` by dividing the master clock, and shifts standard-I2S serial data MSB-first on `i2so_sd`. All outputs are registered in the `clk` domain, so an external `i2si`-style receiver can sample them directly.

---
 rtl/i2so_serializer_if.sv | 25 ++
 rtl/i2so_serializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/i2so_serializer_if.sv
// Sample handshake and I2S output bundle for i2so_serializer.
// master = sample producer / line observer, slave = the serializer.
interface i2so_serializer_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic              en;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic              in_valid;
    logic              in_ready;
    logic              i2so_sck;
    logic              i2so_ws;
    logic              i2so_sd;
    logic              underrun;

    modport master (
        output en, in_left, in_right, in_valid,
        input  in_ready, i2so_sck, i2so_ws, i2so_sd, underrun
    );

    modport slave (
        input  en, in_left, in_right, in_valid,
        output in_ready, i2so_sck, i2so_ws, i2so_sd, underrun
    );
endinterface

// File: rtl/i2so_serializer.sv
// I2S master transmitter: one-entry stereo buffer, clk-divided sck/ws, MSB-first sd.
// Build option I2SO_UNDERRUN_REPEAT_EN: underrun frames repeat the last sent pair instead of zeros.
module i2so_serializer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIV    = 4
) (
    input  logic             clk,
    input  logic             rst,
    i2so_serializer_if.slave bus
);
    localparam int unsigned FRAME_W = 2 * DATA_W;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned DIV_W   = $clog2(DIV);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FRAME_W - 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_full;
    logic               r_ready;
    logic [DATA_W-1:0]  r_buf_l;
    logic [DATA_W-1:0]  r_buf_r;
    logic [FRAME_W-1:0] r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_sck;
    logic               r_ws;
    logic               r_sd;
    logic               r_underrun;

    logic               w_hs;
    logic               w_tick;
    logic               w_shift;
    logic               w_boundary;
    logic               w_start;
    logic               w_load;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic [FRAME_W-1:0] w_buf_word;
    logic [FRAME_W-1:0] w_fill;

    assign w_hs       = bus.in_valid && r_ready;
    assign w_tick     = (r_div_cnt == DIV_LAST);
    // sck 1->0 toggle is the shift event
    assign w_shift    = (r_state == ST_RUN) && w_tick && r_sck;
    assign w_boundary = w_shift && (r_bit_cnt == LAST_BIT);
    assign w_start    = (r_state == ST_IDLE) && bus.en && r_full;
    assign w_load     = w_start || (w_boundary && bus.en && r_full);
    assign w_bit_nxt  = r_bit_cnt + BIT_W'(1);
    assign w_buf_word = {r_buf_l, r_buf_r};

`ifdef I2SO_UNDERRUN_REPEAT_EN
    logic [FRAME_W-1:0] r_last;

    // Last pair moved out of the buffer, replayed on underrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= '0;
        end else if (w_load) begin
            r_last <= w_buf_word;
        end
    end

    assign w_fill = r_last;
`else
    assign w_fill = '0;
`endif

    // One-entry buffer; ready drops on the handshake and returns one clk after the buffer drains
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full  <= 1'b0;
            r_ready <= 1'b1;
            r_buf_l <= '0;
            r_buf_r <= '0;
        end else begin
            r_ready <= !r_full && !w_hs;
            if (w_load) begin
                r_full <= 1'b0;
            end else if (w_hs) begin
                r_full <= 1'b1;
            end
            if (w_hs) begin
                r_buf_l <= bus.in_left;
                r_buf_r <= bus.in_right;
            end
        end
    end

    // Frame FSM, divider, shift register and serial outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_sck      <= 1'b0;
            r_ws       <= 1'b0;
            r_sd       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sck     <= 1'b0;
                    r_ws      <= 1'b0;
                    r_sd      <= 1'b0;
                    r_bit_cnt <= '0;
                    r_div_cnt <= '0;
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_shift <= w_buf_word;
                        r_sd    <= r_buf_l[DATA_W-1];
                    end
                end
                ST_RUN: begin
                    r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
                    if (w_tick) begin
                        r_sck <= !r_sck;
                    end
                    if (w_boundary) begin
                        r_bit_cnt <= '0;
                        r_ws      <= 1'b0;
                        if (!bus.en) begin
                            r_state <= ST_IDLE;
                            r_shift <= '0;
                            r_sd    <= 1'b0;
                        end else if (r_full) begin
                            r_shift <= w_buf_word;
                            r_sd    <= r_buf_l[DATA_W-1];
                        end else begin
                            r_shift    <= w_fill;
                            r_sd       <= w_fill[FRAME_W-1];
                            r_underrun <= 1'b1;
                        end
                    end else if (w_shift) begin
                        r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                        r_sd      <= r_shift[FRAME_W-2];
                        r_bit_cnt <= w_bit_nxt;
                        // ws leads the MSB of each word by one bit
                        r_ws      <= (w_bit_nxt >= WS_FIRST) && (w_bit_nxt <= WS_LAST);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.i2so_sck = r_sck;
    assign bus.i2so_ws  = r_ws;
    assign bus.i2so_sd  = r_sd;
    assign bus.underrun = r_underrun;
endmodule
